alu_seq_stage: RTL and testbench
================================

# alu_seq_stage

Multi-cycle ALU execute stage that sits between the input and output ready-valid pipeline registers of the ALU datapath. Accepts one operand pair plus opcode per transaction and computes one of four operations: subtract, NAND, leading-ones count of {B,A}, or one-hot decode of {B,A}. Subtract and NAND take one cycle. The two scan operations iterate one bit per cycle. The result, with overflow and error flags, is held on a ready-valid output until the downstream stage accepts it.

## Interface
- WIDTH, 4, operand and result width; WIDTH ≥ 2
- i_CLK  in  1  clock, rising edge
- i_RSTn  in  1  reset; asynchronous, active-low
- i_VALID  in  1  upstream operand/opcode valid
- o_READY  out  1  stage can accept a transaction
- i_A  in  WIDTH  operand A, signed two's complement
- i_B  in  WIDTH  operand B, signed two's complement
- i_OP  in  2  opcode: 00 SUB, 01 NAND, 10 LONES, 11 OHDEC
- o_VALID  out  1  result valid
- i_READY  in  1  downstream accepts result
- o_Y  out  WIDTH  result
- o_OVF  out  1  overflow flag
- o_ERR  out  1  error flag

## Operation
- FSM states and transitions:
  - IDLE: o_READY=1. On i_VALID=1, capture i_A, i_B, i_OP into internal registers. Load the scan index: 2·WIDTH−1 for LONES, 0 for OHDEC. Clear the count, first-one position and one-seen registers. Go to CALC.
  - CALC: o_READY=0, o_VALID=0. Per-op behaviour is listed below. When the op completes, register o_Y, o_OVF and o_ERR, then go to DONE.
  - DONE: o_VALID=1 and outputs are stable. On i_READY=1, go to IDLE. While i_READY=0, hold all outputs.
- SUB: Y = A − B, truncated to WIDTH bits. OVF = (A[MSB]≠B[MSB]) && (Y[MSB]≠A[MSB]). ERR=0. Completes in 1 CALC cycle.
- NAND: Y = ~(A & B). OVF=0, ERR=0. Completes in 1 CALC cycle.
- LONES: operate on C = {B,A}, 2·WIDTH bits. Each cycle examine C[idx].
  - If the bit is 1: count++, idx−−.
  - The op completes on the first 0 bit, or after the bit at idx=0 has been examined.
  - Y = count mod 2^WIDTH. OVF = (count > 2^WIDTH−1). ERR=0.
- OHDEC: scan C from idx=0 up to 2·WIDTH−1, one bit per cycle. Always takes 2·WIDTH cycles.
  - On the first 1, record pos=idx.
  - ERR=1 if more than one bit is set, or if no bit is set.
  - Y = pos mod 2^WIDTH; pos=0 when no bit is set. OVF = (pos > 2^WIDTH−1).
- The count and pos registers are sized ⌈log2(2·WIDTH+1)⌉ bits so that they cannot wrap internally.

## Timing
- Reset, asynchronous at any time including mid-CALC or DONE:
  - state=IDLE, o_READY=1, o_VALID=0
  - o_Y=0, o_OVF=0, o_ERR=0
  - captured operands, count, pos and one-seen cleared
  - Any in-flight transaction is discarded.
- Accept happens at the rising edge where state=IDLE and i_VALID=1. Inputs are ignored outside IDLE.
- CALC duration:
  - SUB and NAND: 1 cycle.
  - LONES: min(count+1, 2·WIDTH) cycles.
  - OHDEC: 2·WIDTH cycles.
- o_VALID rises on the edge that ends CALC. Accept-to-valid latency equals the CALC duration.
- Handover happens at the edge where o_VALID=1 and i_READY=1. o_READY is 1 in the following cycle.
- Minimum initiation interval is 3 cycles for SUB (IDLE→CALC→DONE→IDLE). There is no accept in DONE, even if i_READY and i_VALID are high together.
- i_READY held low stalls the stage indefinitely in DONE, and o_READY stays 0.
- Outputs are registered. There is no combinational path from inputs to o_Y, o_OVF or o_ERR.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_SUB, OP_NAND, OP_LONES, OP_OHDEC
  - state encodings IDLE=2'b00, CALC=2'b01, DONE=2'b11
- Sub-module alu_bitscan is the iterative scanner for LONES and OHDEC.
  - Ports: start, mode, vector (2·WIDTH bits), done, count, pos, err_multi.
  - alu_seq_stage instantiates it and handles SUB and NAND inline.

## Test plan
- Reset released, idle: check o_READY=1, o_VALID=0, o_Y=0. Then issue SUB with A=3, B=5 (WIDTH=4). Expect o_Y=4'b1110, o_OVF=0 and o_VALID exactly 1 cycle after accept.
- SUB overflow, A=7, B=−1: expect o_Y=4'b1000, o_OVF=1. Then NAND with A=4'b1100, B=4'b1010: expect o_Y=4'b0111, o_OVF=0, o_ERR=0.
- LONES, 2 cases:
  - B=4'b1111, A=4'b1000: expect o_Y=5 after 6 CALC cycles.
  - B=A=4'b1111: expect o_Y=8, o_OVF=0 after 8 cycles.
  - Repeat both with WIDTH=2 and all ones: expect count 4, o_Y=0, o_OVF=1.
- OHDEC, 3 cases:
  - {B,A}=8'b0000_0100: expect o_Y=2, o_ERR=0.
  - 8'b0001_0100: expect o_Y=2, o_ERR=1.
  - 8'b0: expect o_Y=0, o_ERR=1.
  - Each completes after 8 cycles.
- Backpressure: hold i_READY=0 for 5 cycles in DONE. o_VALID and o_Y stay stable and o_READY stays 0, even with i_VALID=1. Raise i_READY; transfer happens on that edge and o_READY=1 in the next cycle.
- Assert i_RSTn=0 mid-LONES at CALC cycle 3. Outputs clear immediately and asynchronously. After release, a new SUB 1−1 yields o_Y=0 with no residue from the aborted scan.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcodes, FSM state
// encodings and the scanner mode select.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_SUB   = 2'b00,
        OP_NAND  = 2'b01,
        OP_LONES = 2'b10,
        OP_OHDEC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b11
    } state_e;

    // Scanner mode follows opcode bit 0 of the two scan opcodes.
    localparam logic MODE_LONES = 1'b0;
    localparam logic MODE_OHDEC = 1'b1;

endpackage

// File: rtl/alu_bitscan.sv
// Iterative one-bit-per-cycle scanner used by the LONES and OHDEC operations.
// LONES walks from the top bit downwards until the first zero; OHDEC walks the
// whole vector upwards, recording the first set bit and flagging any vector
// that is not exactly one-hot. The count/pos/err_multi outputs already include
// the bit examined in the current cycle, so they are final while done is high.
module alu_bitscan
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(2 * WIDTH + 1),
    localparam int IW = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic [2*WIDTH-1:0]   vector,
    output logic                 done,
    output logic [CW-1:0]        count,
    output logic [CW-1:0]        pos,
    output logic                 err_multi
);

    localparam logic [IW-1:0] LAST_IDX = IW'(2 * WIDTH - 1);

    logic          busy;
    logic          mode_q;
    logic [IW-1:0] idx;
    logic [CW-1:0] count_q, count_nxt;
    logic [CW-1:0] pos_q, pos_nxt;
    logic          seen_q, seen_nxt;
    logic          multi_q, multi_nxt;
    logic          bit_now;

    // Examine the current bit and form the updated scan state and completion.
    always_comb begin
        bit_now   = vector[idx];
        count_nxt = count_q;
        pos_nxt   = pos_q;
        seen_nxt  = seen_q;
        multi_nxt = multi_q;
        done      = 1'b0;
        if (mode_q == MODE_LONES) begin
            if (bit_now) count_nxt = count_q + CW'(1);
            done = busy && (!bit_now || (idx == '0));
        end else begin
            if (bit_now && !seen_q) pos_nxt = CW'(idx);
            if (bit_now && seen_q) multi_nxt = 1'b1;
            if (bit_now) seen_nxt = 1'b1;
            done = busy && (idx == LAST_IDX);
        end
    end

    // Scan state: load on start, advance one bit per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            mode_q  <= MODE_LONES;
            idx     <= '0;
            count_q <= '0;
            pos_q   <= '0;
            seen_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            mode_q  <= mode;
            idx     <= (mode == MODE_OHDEC) ? '0 : LAST_IDX;
            count_q <= '0;
            pos_q   <= '0;
            seen_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (busy) begin
            count_q <= count_nxt;
            pos_q   <= pos_nxt;
            seen_q  <= seen_nxt;
            multi_q <= multi_nxt;
            if (done) begin
                busy <= 1'b0;
            end else if (mode_q == MODE_OHDEC) begin
                idx <= idx + IW'(1);
            end else begin
                idx <= idx - IW'(1);
            end
        end
    end

    assign count = count_nxt;
    assign pos   = pos_nxt;
    // A one-hot decode is in error both for multiple set bits and for none.
    assign err_multi = multi_nxt || !seen_nxt;

endmodule

// File: rtl/alu_seq_stage.sv
// Multi-cycle ALU execute stage with ready-valid handshakes on both sides.
// SUB and NAND resolve in a single CALC cycle; LONES and OHDEC are delegated
// to the iterative alu_bitscan. Results are registered and held in DONE until
// the downstream stage takes them.
module alu_seq_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTn,
    input  logic                    i_VALID,
    output logic                    o_READY,
    input  logic signed [WIDTH-1:0] i_A,
    input  logic signed [WIDTH-1:0] i_B,
    input  logic [1:0]              i_OP,
    output logic                    o_VALID,
    input  logic                    i_READY,
    output logic [WIDTH-1:0]        o_Y,
    output logic                    o_OVF,
    output logic                    o_ERR
);

    localparam int CW = $clog2(2 * WIDTH + 1);

    state_e                  state, state_nxt;
    logic signed [WIDTH-1:0] a_q, b_q;
    op_e                     op_q;
    logic                    accept;
    logic                    scan_start;
    logic                    scan_done;
    logic [CW-1:0]           scan_count;
    logic [CW-1:0]           scan_pos;
    logic                    scan_err;
    logic                    op_done;
    logic signed [WIDTH-1:0] diff;
    logic [WIDTH-1:0]        y_nxt;
    logic                    ovf_nxt;
    logic                    err_nxt;

    // True when a scan result does not fit in the WIDTH-bit result bus.
    function automatic logic exceeds_width(input logic [CW-1:0] v);
        return (v >> WIDTH) != '0;
    endfunction

    assign accept     = (state == IDLE) && i_VALID;
    assign scan_start = accept && i_OP[1];

    alu_bitscan #(
        .WIDTH (WIDTH)
    ) u_scan (
        .clk       (i_CLK),
        .rst_n     (i_RSTn),
        .start     (scan_start),
        .mode      (i_OP[0]),
        .vector    ({b_q, a_q}),
        .done      (scan_done),
        .count     (scan_count),
        .pos       (scan_pos),
        .err_multi (scan_err)
    );

    assign op_done = (op_q == OP_SUB) || (op_q == OP_NAND) || scan_done;

    // FSM state register.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_VALID) state_nxt = CALC;
            CALC:    if (op_done) state_nxt = DONE;
            DONE:    if (i_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from the registered state.
    always_comb begin
        o_READY = (state == IDLE);
        o_VALID = (state == DONE);
    end

    // Operand capture on accept; held stable for the whole calculation.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_SUB;
        end else if (accept) begin
            a_q  <= i_A;
            b_q  <= i_B;
            op_q <= op_e'(i_OP);
        end
    end

    // Result and flag selection for the captured opcode.
    always_comb begin
        diff    = a_q - b_q;
        y_nxt   = '0;
        ovf_nxt = 1'b0;
        err_nxt = 1'b0;
        case (op_q)
            OP_SUB: begin
                y_nxt   = diff;
                ovf_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NAND: begin
                y_nxt = ~(a_q & b_q);
            end
            OP_LONES: begin
                y_nxt   = WIDTH'(scan_count);
                ovf_nxt = exceeds_width(scan_count);
            end
            OP_OHDEC: begin
                y_nxt   = WIDTH'(scan_pos);
                ovf_nxt = exceeds_width(scan_pos);
                err_nxt = scan_err;
            end
            default: ;
        endcase
    end

    // Result registers: loaded on the cycle that finishes CALC, held otherwise.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            o_Y   <= '0;
            o_OVF <= 1'b0;
            o_ERR <= 1'b0;
        end else if ((state == CALC) && op_done) begin
            o_Y   <= y_nxt;
            o_OVF <= ovf_nxt;
            o_ERR <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_seq_stage.sv
// Self-checking bench for alu_seq_stage: directed cases, randomized
// transactions against an arithmetic reference model, backpressure and
// asynchronous reset in mid-scan. A second, 2-bit-wide instance covers the
// scan-result wrap cases.
module tb_alu_seq_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              v4, rdy4, ov4, r4, ovf4, err4;
    logic signed [3:0] a4, b4;
    logic [1:0]        op4;
    logic [3:0]        y4;

    logic              v2, rdy2, ov2, r2, ovf2, err2;
    logic signed [1:0] a2, b2;
    logic [1:0]        op2;
    logic [1:0]        y2;

    int n_checks = 0;
    int n_fails  = 0;

    alu_seq_stage #(.WIDTH(4)) dut4 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(v4), .o_READY(rdy4),
        .i_A(a4), .i_B(b4), .i_OP(op4), .o_VALID(ov4), .i_READY(r4),
        .o_Y(y4), .o_OVF(ovf4), .o_ERR(err4)
    );

    alu_seq_stage #(.WIDTH(2)) dut2 (
        .i_CLK(clk), .i_RSTn(rst_n), .i_VALID(v2), .o_READY(rdy2),
        .i_A(a2), .i_B(b2), .i_OP(op2), .o_VALID(ov2), .i_READY(r2),
        .o_Y(y2), .o_OVF(ovf2), .o_ERR(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: result, flags and CALC length from plain arithmetic.
    function automatic void model(input int w, input int a, input int b, input int op,
                                  output int y, output bit ovf, output bit err, output int cyc);
        int mask, half, sa, sb, d, c, n, cnt, pop, pos;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        n    = 2 * w;
        a    = a & mask;
        b    = b & mask;
        c    = (b << w) | a;
        y = 0; ovf = 1'b0; err = 1'b0; cyc = 1;
        case (op)
            0: begin
                sa  = (a >= half) ? a - (1 << w) : a;
                sb  = (b >= half) ? b - (1 << w) : b;
                d   = sa - sb;
                y   = d & mask;
                ovf = (d >= half) || (d < -half);
            end
            1: y = (~(a & b)) & mask;
            2: begin
                cnt = 0;
                for (int i = n - 1; i >= 0; i--) begin
                    if (((c >> i) & 1) == 0) break;
                    cnt++;
                end
                y   = cnt & mask;
                ovf = cnt > mask;
                cyc = (cnt + 1 < n) ? cnt + 1 : n;
            end
            default: begin
                pop = 0;
                pos = -1;
                for (int i = 0; i < n; i++) begin
                    if (((c >> i) & 1) == 1) begin
                        pop++;
                        if (pos < 0) pos = i;
                    end
                end
                if (pos < 0) pos = 0;
                y   = pos & mask;
                ovf = pos > mask;
                err = (pop != 1);
                cyc = n;
            end
        endcase
    endfunction

    // One full transaction on the 4-bit instance with optional DONE stall.
    task automatic do_txn(input string tag, input int a, input int b, input int op, input int stall);
        int  ey, ecyc, lat;
        bit  eovf, eerr;
        model(4, a, b, op, ey, eovf, eerr, ecyc);
        @(negedge clk);
        check({tag, ".in_ready"}, 32'(rdy4), 1);
        v4 = 1'b1; a4 = 4'(a); b4 = 4'(b); op4 = 2'(op);
        @(posedge clk); #1;
        v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); op4 = 2'($urandom);
        lat = 0;
        while (!ov4 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, ecyc);
        check({tag, ".y"}, 32'(y4), ey);
        check({tag, ".ovf"}, 32'(ovf4), 32'(eovf));
        check({tag, ".err"}, 32'(err4), 32'(eerr));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            v4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom);
            @(posedge clk); #1;
            check({tag, ".stall_valid"}, 32'(ov4), 1);
            check({tag, ".stall_y"}, 32'(y4), ey);
            check({tag, ".stall_ready"}, 32'(rdy4), 0);
        end
        @(negedge clk);
        r4 = 1'b1;
        if (stall > 0) v4 = 1'b1;
        @(posedge clk); #1;
        v4 = 1'b0; r4 = 1'b0;
        check({tag, ".handover_valid"}, 32'(ov4), 0);
        check({tag, ".handover_ready"}, 32'(rdy4), 1);
    endtask

    // One transaction on the 2-bit instance, no stall.
    task automatic do_txn2(input string tag, input int a, input int b, input int op);
        int  ey, ecyc, lat;
        bit  eovf, eerr;
        model(2, a, b, op, ey, eovf, eerr, ecyc);
        @(negedge clk);
        v2 = 1'b1; a2 = 2'(a); b2 = 2'(b); op2 = 2'(op);
        @(posedge clk); #1;
        v2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, ecyc);
        check({tag, ".y"}, 32'(y2), ey);
        check({tag, ".ovf"}, 32'(ovf2), 32'(eovf));
        check({tag, ".err"}, 32'(err2), 32'(eerr));
        @(negedge clk);
        r2 = 1'b1;
        @(posedge clk); #1;
        r2 = 1'b0;
        check({tag, ".handover_ready"}, 32'(rdy2), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        v4 = 1'b0; r4 = 1'b0; a4 = '0; b4 = '0; op4 = '0;
        v2 = 1'b0; r2 = 1'b0; a2 = '0; b2 = '0; op2 = '0;
        #12;
        check("rst.ready", 32'(rdy4), 1);
        check("rst.valid", 32'(ov4), 0);
        check("rst.y", 32'(y4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle.ready", 32'(rdy4), 1);
        check("idle.valid", 32'(ov4), 0);
        check("idle.y", 32'(y4), 0);

        // Directed cases on the 4-bit instance.
        do_txn("sub_3_5", 3, 5, 0, 0);
        do_txn("sub_ovf", 7, 15, 0, 0);
        do_txn("nand", 4'b1100, 4'b1010, 1, 0);
        do_txn("lones_5", 4'b1000, 4'b1111, 2, 0);
        do_txn("lones_8", 4'b1111, 4'b1111, 2, 0);
        do_txn("ohdec_ok", 4'b0100, 4'b0000, 3, 0);
        do_txn("ohdec_multi", 4'b0100, 4'b0001, 3, 0);
        do_txn("ohdec_none", 0, 0, 3, 0);
        do_txn("ohdec_top", 0, 4'b1000, 3, 0);
        do_txn("backpressure", 5, 2, 0, 5);

        // Randomized transactions against the model.
        for (int k = 0; k < 24; k++) begin
            do_txn("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Leave a nonzero result on the bus, then reset in the third LONES cycle.
        do_txn("pre_rst_nand", 4'b1100, 4'b1010, 1, 0);
        @(negedge clk);
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; op4 = 2'b10;
        @(posedge clk); #1;
        v4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.ready", 32'(rdy4), 1);
        check("midrst.valid", 32'(ov4), 0);
        check("midrst.y", 32'(y4), 0);
        check("midrst.ovf", 32'(ovf4), 0);
        check("midrst.err", 32'(err4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn("post_rst_sub", 1, 1, 0, 0);

        // 2-bit instance: scan results that exceed the result width.
        do_txn2("w2_lones_all", 2'b11, 2'b11, 2);
        do_txn2("w2_ohdec_top", 2'b00, 2'b10, 3);
        for (int k = 0; k < 8; k++) begin
            do_txn2("w2_rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
